// File: rtl/pa_noc_pkg.sv
// Packet layout, APB address fields, FSM states and packet helpers for the NI
// APB requester.
package pa_noc;

  localparam int unsigned APB_PACKET_WIDTH = 59;
  localparam int unsigned COORD_W          = 2;
  localparam int unsigned ADDR_W           = 16;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned PADDR_W          = 20;

  localparam int unsigned PKT_DST_COL_LSB  = 0;
  localparam int unsigned PKT_DST_ROW_LSB  = 2;
  localparam int unsigned PKT_SRC_COL_LSB  = 4;
  localparam int unsigned PKT_SRC_ROW_LSB  = 6;
  localparam int unsigned PKT_VALID_BIT    = 8;
  localparam int unsigned PKT_IS_RESP_BIT  = 9;
  localparam int unsigned PKT_WR_ERR_BIT   = 10;
  localparam int unsigned PKT_ADDR_LSB     = 11;
  localparam int unsigned PKT_DATA_LSB     = 27;

  localparam int unsigned PADDR_ROW_LSB    = 18;
  localparam int unsigned PADDR_COL_LSB    = 16;

  typedef logic [COORD_W-1:0] coord_t;

  // Bit 10 carries pwrite in a request and slverr in a response.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              wr_err;
    logic              is_resp;
    logic              valid;
    coord_t            src_row;
    coord_t            src_col;
    coord_t            dst_row;
    coord_t            dst_col;
  } apb_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } ni_state_e;

  function automatic coord_t paddr_row(input logic [PADDR_W-1:0] paddr);
    return paddr[PADDR_ROW_LSB +: COORD_W];
  endfunction

  function automatic coord_t paddr_col(input logic [PADDR_W-1:0] paddr);
    return paddr[PADDR_COL_LSB +: COORD_W];
  endfunction

  function automatic apb_pkt_t build_req(input coord_t            my_row,
                                         input coord_t            my_col,
                                         input logic [PADDR_W-1:0] paddr,
                                         input logic              pwrite,
                                         input logic [DATA_W-1:0] pwdata);
    logic [APB_PACKET_WIDTH-1:0] v;
    v = '0;
    v[PKT_DST_COL_LSB +: COORD_W] = paddr_col(paddr);
    v[PKT_DST_ROW_LSB +: COORD_W] = paddr_row(paddr);
    v[PKT_SRC_COL_LSB +: COORD_W] = my_col;
    v[PKT_SRC_ROW_LSB +: COORD_W] = my_row;
    v[PKT_VALID_BIT]              = 1'b1;
    v[PKT_IS_RESP_BIT]            = 1'b0;
    v[PKT_WR_ERR_BIT]             = pwrite;
    v[PKT_ADDR_LSB +: ADDR_W]     = paddr[ADDR_W-1:0];
    v[PKT_DATA_LSB +: DATA_W]     = pwrite ? pwdata : '0;
    return apb_pkt_t'(v);
  endfunction

  function automatic logic resp_match(input apb_pkt_t p,
                                      input coord_t   my_row,
                                      input coord_t   my_col,
                                      input coord_t   peer_row,
                                      input coord_t   peer_col);
    return p.valid && p.is_resp &&
           (p.dst_row == my_row) && (p.dst_col == my_col) &&
           (p.src_row == peer_row) && (p.src_col == peer_col);
  endfunction

endpackage

// File: rtl/ni_apb_requester.sv
// Requester NI: turns one APB transfer into a request packet, waits for the
// matching response (or a timeout) and completes the APB access.
module ni_apb_requester
  import pa_noc::*;
#(
  parameter int unsigned GRID_WIDTH     = 4,
  parameter int unsigned NI_ROW         = 0,
  parameter int unsigned NI_COL         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        i_clk,
  input  logic                        i_arst,
  input  logic                        i_psel,
  input  logic                        i_penable,
  input  logic                        i_pwrite,
  input  logic [PADDR_W-1:0]          i_paddr,
  input  logic [DATA_W-1:0]           i_pwdata,
  output logic                        o_pready,
  output logic [DATA_W-1:0]           o_prdata,
  output logic                        o_pslverr,
  output logic [APB_PACKET_WIDTH-1:0] o_apbPacket,
  input  logic [APB_PACKET_WIDTH-1:0] i_apbPacket
);

  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam coord_t      MY_ROW   = COORD_W'(NI_ROW % GRID_WIDTH);
  localparam coord_t      MY_COL   = COORD_W'(NI_COL % GRID_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ni_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  coord_t            dst_row_q, dst_row_d;
  coord_t            dst_col_q, dst_col_d;
  logic              write_q, write_d;
  apb_pkt_t          pkt_q, pkt_d;
  logic              pready_q, pready_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;

  apb_pkt_t rsp_pkt;
  logic     setup_c, self_c, match_c, timeout_c;
  logic     unused_rsp_addr;

  assign rsp_pkt         = apb_pkt_t'(i_apbPacket);
  assign setup_c         = i_psel && !i_penable;
  assign self_c          = (paddr_row(i_paddr) == MY_ROW) && (paddr_col(i_paddr) == MY_COL);
  assign match_c         = resp_match(rsp_pkt, MY_ROW, MY_COL, dst_row_q, dst_col_q);
  assign timeout_c       = (cnt_q == CNT_LAST);
  assign unused_rsp_addr = ^rsp_pkt.addr;

  // State and output registers
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dst_row_q <= '0;
      dst_col_q <= '0;
      write_q   <= 1'b0;
      pkt_q     <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dst_row_q <= dst_row_d;
      dst_col_q <= dst_col_d;
      write_q   <= write_d;
      pkt_q     <= pkt_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Next-state logic; losing psel before DONE aborts the transfer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (setup_c) state_d = self_c ? ST_DONE : ST_SEND;
      ST_SEND: state_d = i_psel ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!i_psel)                    state_d = ST_IDLE;
        else if (match_c || timeout_c) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, captured request and wait counter
  always_comb begin
    cnt_d     = cnt_q;
    dst_row_d = dst_row_q;
    dst_col_d = dst_col_q;
    write_d   = write_q;
    pkt_d     = '0;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (setup_c) begin
          dst_row_d = paddr_row(i_paddr);
          dst_col_d = paddr_col(i_paddr);
          write_d   = i_pwrite;
          if (self_c) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            pkt_d = build_req(MY_ROW, MY_COL, i_paddr, i_pwrite, i_pwdata);
          end
        end
      end
      ST_SEND: cnt_d = '0;
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_psel) begin
          // A response landing on the timeout cycle still wins
          if (match_c) begin
            pready_d  = 1'b1;
            prdata_d  = write_q ? '0 : rsp_pkt.data;
            pslverr_d = rsp_pkt.wr_err;
          end else if (timeout_c) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_pready    = pready_q;
  assign o_prdata    = prdata_q;
  assign o_pslverr   = pslverr_q;
  assign o_apbPacket = pkt_q;

endmodule

// File: tb/tb_ni_apb_requester.sv
// Bench for ni_apb_requester: drives APB transfers, plays the remote side of
// the network from a memory model and scoreboards completions and packets.
module tb_ni_apb_requester;

  localparam int NI_R = 1;
  localparam int NI_C = 1;
  localparam int TMO  = 8;
  localparam int PW   = 59;

  logic          clk, rst;
  logic          psel, penable, pwrite;
  logic [19:0]   paddr;
  logic [31:0]   pwdata;
  logic          pready, pslverr;
  logic [31:0]   prdata;
  logic [PW-1:0] pkt_out, pkt_in;

  ni_apb_requester #(
    .GRID_WIDTH(4), .NI_ROW(NI_R), .NI_COL(NI_C), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_arst(rst), .i_psel(psel), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
    .o_pready(pready), .o_prdata(prdata), .o_pslverr(pslverr),
    .o_apbPacket(pkt_out), .i_apbPacket(pkt_in)
  );

  typedef struct { logic [31:0] rdata; logic err; int lat; } exp_rsp_t;
  typedef struct { logic [PW-1:0] pkt; int lat; } exp_pkt_t;

  exp_rsp_t    exp_rsp_q[$];
  exp_pkt_t    exp_pkt_q[$];
  logic [31:0] mem [logic [19:0]];
  int          checks = 0, failures = 0;
  int          cyc = 0, setup_cyc = 0;
  exp_rsp_t    er;
  exp_pkt_t    ep;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packet encoding written out from the field positions.
  function automatic logic [PW-1:0] make_pkt(input int dr, input int dc, input int sr, input int sc,
                                             input logic v, input logic r, input logic b10,
                                             input logic [15:0] a, input logic [31:0] d);
    logic [PW-1:0] p;
    p = PW'(dc & 3) | (PW'(dr & 3) << 2) | (PW'(sc & 3) << 4) | (PW'(sr & 3) << 6) |
        (PW'(v) << 8) | (PW'(r) << 9) | (PW'(b10) << 10) | (PW'(a) << 11) | (PW'(d) << 27);
    return p;
  endfunction

  // Monitor: completions and outgoing packets against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (pready) begin
        if (exp_rsp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pready: got prdata=%h pslverr=%0d at cycle %0d, required none", prdata, pslverr, cyc);
        end else begin
          er = exp_rsp_q.pop_front();
          if (prdata !== er.rdata || pslverr !== er.err || (cyc - setup_cyc) != er.lat) begin
            failures++;
            $display("FAIL completion: got prdata=%h pslverr=%0d lat=%0d, required prdata=%h pslverr=%0d lat=%0d",
                     prdata, pslverr, cyc - setup_cyc, er.rdata, er.err, er.lat);
          end
        end
      end else if (prdata !== 32'h0 || pslverr !== 1'b0) begin
        failures++;
        $display("FAIL idle_outputs: got prdata=%h pslverr=%0d, required 0/0", prdata, pslverr);
      end
      if (pkt_out !== '0) begin
        checks++;
        if (exp_pkt_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_packet: got %h, required all-zero bus", pkt_out);
        end else begin
          ep = exp_pkt_q.pop_front();
          if (pkt_out !== ep.pkt || (cyc - setup_cyc) != ep.lat) begin
            failures++;
            $display("FAIL request_packet: got %h lat=%0d, required %h lat=%0d",
                     pkt_out, cyc - setup_cyc, ep.pkt, ep.lat);
          end
        end
      end
    end
  end

  task automatic apb_setup(input logic w, input logic [19:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    setup_cyc = cyc;
    @(posedge clk); #1;
    penable = 1'b1;
  endtask

  task automatic wait_pready();
    int n;
    n = 0;
    checks++;
    while (n < 40) begin
      @(negedge clk);
      if (pready) break;
      n++;
    end
    if (n == 40) begin
      failures++;
      $display("FAIL pready_timeout: got no pready within 40 cycles, required a completion");
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic drive_pkt(input logic [PW-1:0] p);
    pkt_in = p;
    @(posedge clk); #1;
    pkt_in = '0;
  endtask

  task automatic do_xfer(input logic w, input logic [19:0] a, input logic [31:0] d,
                         input bit tmo, input int dly, input bit noise, input logic err);
    int dr, dc;
    logic [31:0] rd;
    dr = int'(a[19:18]);
    dc = int'(a[17:16]);
    if (dr == NI_R && dc == NI_C) begin
      exp_rsp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
      apb_setup(w, a, d);
      wait_pready();
      return;
    end
    exp_pkt_q.push_back('{pkt: make_pkt(dr, dc, NI_R, NI_C, 1'b1, 1'b0, w, a[15:0], w ? d : 32'h0), lat: 1});
    if (tmo) begin
      exp_rsp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: TMO + 2});
      apb_setup(w, a, d);
      wait_pready();
      return;
    end
    if (w) begin
      mem[a] = d;
      rd = $urandom;
    end else begin
      if (!mem.exists(a)) mem[a] = $urandom;
      rd = mem[a];
    end
    exp_rsp_q.push_back('{rdata: w ? 32'h0 : rd, err: err, lat: 3 + dly + (noise ? 3 : 0)});
    apb_setup(w, a, d);
    @(posedge clk); #1;
    repeat (dly) begin @(posedge clk); #1; end
    if (noise) begin
      drive_pkt(make_pkt(NI_R, NI_C, dr, dc, 1'b1, 1'b0, ~err, a[15:0], ~rd));
      drive_pkt(make_pkt(NI_R, NI_C, 3, 3, 1'b1, 1'b1, ~err, a[15:0], ~rd));
      drive_pkt(make_pkt(NI_R, NI_C, dr, dc, 1'b0, 1'b1, ~err, a[15:0], ~rd));
    end
    drive_pkt(make_pkt(NI_R, NI_C, dr, dc, 1'b1, 1'b1, err, a[15:0], rd));
    wait_pready();
  endtask

  task automatic check_quiet(input string name);
    @(negedge clk);
    checks++;
    if ({pready, prdata, pslverr, pkt_out} !== '0) begin
      failures++;
      $display("FAIL %s: got pready=%0d prdata=%h pslverr=%0d pkt=%h, required all 0",
               name, pready, prdata, pslverr, pkt_out);
    end
  endtask

  initial begin
    logic [19:0] a;
    bit          tmo, noise;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pkt_in = '0;
    check_quiet("reset_state");
    check_quiet("reset_state_hold");
    @(posedge clk); #1 rst = 1'b0;

    // Directed: write to (2,3); response data on a write must not reach prdata
    do_xfer(1'b1, 20'hB0010, 32'hDEADBEEF, 1'b0, 3, 1'b0, 1'b0);
    // Directed: read from (0,2)
    mem[20'h20040] = 32'h12345678;
    do_xfer(1'b0, 20'h20040, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    // Timeout, then self-addressed
    do_xfer(1'b0, 20'h30008, 32'h0, 1'b1, 0, 1'b0, 1'b0);
    do_xfer(1'b0, 20'h50004, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    do_xfer(1'b1, 20'h50008, 32'h55AA55AA, 1'b0, 0, 1'b0, 1'b0);
    // Noise packets during WAIT, slverr response, response on the timeout cycle
    do_xfer(1'b0, 20'h80100, 32'h0, 1'b0, 1, 1'b1, 1'b0);
    do_xfer(1'b0, 20'hC0200, 32'h0, 1'b0, 2, 1'b0, 1'b1);
    do_xfer(1'b0, 20'h10300, 32'h0, 1'b0, TMO - 1, 1'b0, 1'b0);

    // Reset in WAIT: the late response must be ignored
    exp_pkt_q.push_back('{pkt: make_pkt(1, 0, NI_R, NI_C, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0), lat: 1});
    apb_setup(1'b0, 20'h40020, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    check_quiet("reset_mid_wait");
    @(posedge clk); #1 rst = 1'b0;
    drive_pkt(make_pkt(NI_R, NI_C, 1, 0, 1'b1, 1'b1, 1'b0, 16'h0020, 32'hBAD0BAD0));
    repeat (3) @(negedge clk);
    check_quiet("after_reset_response");

    // psel dropped in WAIT: no completion, later response dropped
    exp_pkt_q.push_back('{pkt: make_pkt(2, 1, NI_R, NI_C, 1'b1, 1'b0, 1'b0, 16'h0044, 32'h0), lat: 1});
    apb_setup(1'b0, 20'h90044, 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    drive_pkt(make_pkt(NI_R, NI_C, 2, 1, 1'b1, 1'b1, 1'b0, 16'h0044, 32'h0BADF00D));
    repeat (3) @(negedge clk);
    check_quiet("after_abort");

    // Randomized traffic against the remote-memory model
    for (int i = 0; i < 40; i++) begin
      a     = 20'($urandom);
      if ($urandom_range(0, 2) == 0) a[19:16] = 4'($urandom_range(0, 3));
      tmo   = ($urandom_range(0, 7) == 0);
      noise = ($urandom_range(0, 5) == 0) && (a[19:16] != 4'hF);
      do_xfer(1'($urandom), a, $urandom, tmo, $urandom_range(0, 4), noise, 1'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    checks++;
    if (exp_rsp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_completions: got %0d left, required 0", exp_rsp_q.size());
    end
    checks++;
    if (exp_pkt_q.size() != 0) begin
      failures++;
      $display("FAIL pending_packets: got %0d left, required 0", exp_pkt_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
